// File: rtl/pb_event_pkg.sv
// Shared types and default timing constants for the push-button event controller.
package pb_event_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DB_DN,
        S_DOWN,
        S_DB_UP,
        S_GAP
    } pb_state_e;

    localparam int DEF_CNT_W    = 16;
    localparam int DEF_DB_CYC   = 1000;
    localparam int DEF_LONG_CYC = 50000;
    localparam int DEF_DCLK_CYC = 20000;

endpackage

// File: rtl/pb_sync.sv
// Two-flop synchronizer for the raw button; presets to 1 (released) on reset.
module pb_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_q    <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pb_event_ctrl.sv
// Debounces an active-low push-button and classifies gestures into
// single-cycle short / long / double-click events.
module pb_event_ctrl
    import pb_event_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int DB_CYC   = DEF_DB_CYC,
    parameter int LONG_CYC = DEF_LONG_CYC,
    parameter int DCLK_CYC = DEF_DCLK_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic PB,
    input  logic en,
    output logic short_evt,
    output logic long_evt,
    output logic dbl_evt,
    output logic held,
    output logic busy
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DCLK_LAST = CNT_W'(DCLK_CYC - 1);

    logic             w_pb_s;
    pb_state_e        r_state;
    logic [CNT_W-1:0] r_db_cnt;
    logic [CNT_W-1:0] r_tm_cnt;
    logic             r_second;
    logic             r_long;
    logic             w_long_now;
    logic             w_long_any;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    pb_sync u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (PB),
        .o_q (w_pb_s)
    );

    // Long qualifies in DOWN and DB_UP; a release completing in the same
    // cycle must still see it so the gesture ends without a second event.
    assign w_long_now = (r_tm_cnt == LONG_LAST) && !r_long;
    assign w_long_any = r_long || w_long_now;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_db_cnt  <= '0;
            r_tm_cnt  <= '0;
            r_second  <= 1'b0;
            r_long    <= 1'b0;
            short_evt <= 1'b0;
            long_evt  <= 1'b0;
            dbl_evt   <= 1'b0;
            held      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            short_evt <= 1'b0;
            long_evt  <= 1'b0;
            dbl_evt   <= 1'b0;
            if (!en) begin
                r_state  <= S_IDLE;
                r_db_cnt <= '0;
                r_tm_cnt <= '0;
                r_second <= 1'b0;
                r_long   <= 1'b0;
                held     <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_pb_s) begin
                            r_state  <= S_DB_DN;
                            r_db_cnt <= '0;
                            r_second <= 1'b0;
                            r_long   <= 1'b0;
                            busy     <= 1'b1;
                        end
                    end
                    S_DB_DN: begin
                        // Keeps running so a bounced second press resumes the gap window.
                        r_tm_cnt <= sat_inc(r_tm_cnt);
                        if (w_pb_s) begin
                            if (r_second) begin
                                r_state <= S_GAP;
                            end else begin
                                r_state <= S_IDLE;
                                busy    <= 1'b0;
                            end
                        end else if (r_db_cnt == DB_LAST) begin
                            r_state  <= S_DOWN;
                            r_tm_cnt <= '0;
                            held     <= 1'b1;
                        end else begin
                            r_db_cnt <= sat_inc(r_db_cnt);
                        end
                    end
                    S_DOWN: begin
                        r_tm_cnt <= sat_inc(r_tm_cnt);
                        if (w_long_now) begin
                            long_evt <= 1'b1;
                            r_long   <= 1'b1;
                        end
                        if (w_pb_s) begin
                            r_state  <= S_DB_UP;
                            r_db_cnt <= '0;
                        end
                    end
                    S_DB_UP: begin
                        r_tm_cnt <= sat_inc(r_tm_cnt);
                        if (w_long_now) begin
                            long_evt <= 1'b1;
                            r_long   <= 1'b1;
                        end
                        if (!w_pb_s) begin
                            r_state <= S_DOWN;
                        end else if (r_db_cnt == DB_LAST) begin
                            held <= 1'b0;
                            if (w_long_any) begin
                                r_state <= S_IDLE;
                                busy    <= 1'b0;
                            end else if (r_second) begin
                                dbl_evt <= 1'b1;
                                r_state <= S_IDLE;
                                busy    <= 1'b0;
                            end else begin
                                r_state  <= S_GAP;
                                r_tm_cnt <= '0;
                            end
                        end else begin
                            r_db_cnt <= sat_inc(r_db_cnt);
                        end
                    end
                    S_GAP: begin
                        r_tm_cnt <= sat_inc(r_tm_cnt);
                        if (r_tm_cnt >= DCLK_LAST) begin
                            short_evt <= 1'b1;
                            r_state   <= S_IDLE;
                            busy      <= 1'b0;
                        end else if (!w_pb_s) begin
                            r_state  <= S_DB_DN;
                            r_db_cnt <= '0;
                            r_second <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        held    <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pb_event_ctrl.sv
// Directed bench for pb_event_ctrl with short timing (DB=4, LONG=20, DCLK=10).
module tb_pb_event_ctrl;

    logic clk;
    logic rst;
    logic PB;
    logic en;
    logic short_evt;
    logic long_evt;
    logic dbl_evt;
    logic held;
    logic busy;

    int n_chk;
    int n_err;
    int n_short;
    int n_long;
    int n_dbl;
    int n_multi;

    pb_event_ctrl #(
        .CNT_W    (16),
        .DB_CYC   (4),
        .LONG_CYC (20),
        .DCLK_CYC (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .PB        (PB),
        .en        (en),
        .short_evt (short_evt),
        .long_evt  (long_evt),
        .dbl_evt   (dbl_evt),
        .held      (held),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (short_evt) n_short++;
        if (long_evt)  n_long++;
        if (dbl_evt)   n_dbl++;
        if (int'(short_evt) + int'(long_evt) + int'(dbl_evt) > 1) n_multi++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int s0, l0, d0, bad, lat;
        bit found;
        n_chk = 0; n_err = 0;
        n_short = 0; n_long = 0; n_dbl = 0; n_multi = 0;

        // Reset with button pressed, then release reset with button idle.
        rst = 1'b1; PB = 1'b0; en = 1'b1;
        #23;
        chk("rst_short", int'(short_evt), 0);
        chk("rst_long",  int'(long_evt),  0);
        chk("rst_dbl",   int'(dbl_evt),   0);
        chk("rst_held",  int'(held),      0);
        chk("rst_busy",  int'(busy),      0);
        PB = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (busy || held || short_evt || long_evt || dbl_evt) bad++;
        end
        chk("idle_quiet", bad, 0);

        // Short click: 10 cycles low, event 17 cycles after the rising edge.
        s0 = n_short; l0 = n_long; d0 = n_dbl;
        PB = 1'b0;
        cyc(10);
        PB = 1'b1;
        found = 0; lat = 0;
        for (int c = 1; c <= 40 && !found; c++) begin
            @(negedge clk);
            if (short_evt) begin found = 1; lat = c; end
        end
        chk("short_lat", lat, 17);
        cyc(20);
        chk("short_cnt", n_short - s0, 1);
        chk("short_nolong", n_long - l0, 0);
        chk("short_nodbl", n_dbl - d0, 0);

        // Long press: 30 cycles low, event 27 cycles after the falling edge.
        s0 = n_short; l0 = n_long; d0 = n_dbl;
        PB = 1'b0;
        found = 0; lat = 0; bad = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (long_evt && !found) begin
                found = 1; lat = c;
                if (!held) bad++;
            end
        end
        chk("long_lat", lat, 27);
        chk("long_held", bad, 0);
        PB = 1'b1;
        cyc(40);
        chk("long_cnt", n_long - l0, 1);
        chk("long_noshort", n_short - s0, 0);
        chk("long_nodbl", n_dbl - d0, 0);

        // Double click: 8 low, 5 high, 8 low.
        s0 = n_short; l0 = n_long; d0 = n_dbl;
        PB = 1'b0; cyc(8);
        PB = 1'b1; cyc(5);
        PB = 1'b0; cyc(8);
        PB = 1'b1; cyc(40);
        chk("dbl_cnt", n_dbl - d0, 1);
        chk("dbl_noshort", n_short - s0, 0);
        chk("dbl_nolong", n_long - l0, 0);

        // Low glitches every 3 cycles never pass debounce.
        s0 = n_short; l0 = n_long; d0 = n_dbl;
        for (int c = 0; c < 30; c++) begin
            PB = (c % 3 == 0) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        PB = 1'b1;
        cyc(10);
        chk("bounce_busy", int'(busy), 0);
        chk("bounce_evts", (n_short - s0) + (n_long - l0) + (n_dbl - d0), 0);

        // One-cycle high glitch while held: held never drops, one short click.
        s0 = n_short; l0 = n_long; d0 = n_dbl;
        PB = 1'b0;
        bad = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c >= 8 && !held) bad++;
            if (c == 10) PB = 1'b1;
            if (c == 11) PB = 1'b0;
        end
        chk("glitch_held", bad, 0);
        PB = 1'b1;
        cyc(40);
        chk("glitch_short", n_short - s0, 1);
        chk("glitch_nolong", n_long - l0, 0);

        // Drop en during the gap after a click: silent abort.
        s0 = n_short;
        PB = 1'b0; cyc(8);
        PB = 1'b1;
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (!held && busy) found = 1;
        end
        chk("gap_reached", int'(found), 1);
        en = 1'b0;
        @(negedge clk);
        chk("en_busy", int'(busy), 0);
        chk("en_held", int'(held), 0);
        en = 1'b1;
        cyc(30);
        chk("en_noshort", n_short - s0, 0);

        // Asynchronous reset mid-press.
        s0 = n_short; l0 = n_long; d0 = n_dbl;
        PB = 1'b0;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (held) found = 1;
        end
        chk("down_reached", int'(found), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_held", int'(held), 0);
        chk("arst_busy", int'(busy), 0);
        @(negedge clk);
        PB = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(40);
        chk("arst_evts", (n_short - s0) + (n_long - l0) + (n_dbl - d0), 0);

        chk("one_evt_per_cyc", n_multi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
